// File: rtl/card_dealer.sv
// Card dealer: seeds a 12-bit LFSR from the Counter, runs the 2 s timer handshake per draw,
// and deals ranks 1..13 from a tracked 52-card deck (at most 4 of each rank).
module card_dealer #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 150000000,
  parameter int TO_W    = 28
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Seed,
  input  logic             i_SeedLoad,
  input  logic             i_Shuffle,
  input  logic             i_DrawReq,
  input  logic             i_TwoSec,
  output logic             o_RstCounter,
  output logic             o_Active,
  output logic [3:0]       o_Card,
  output logic             o_CardValid,
  output logic             o_Busy,
  output logic             o_DeckEmpty,
  output logic             o_Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [11:0]     lfsr;
  logic [11:0]     lfsr_next;
  logic [2:0]      counts [16];
  logic [5:0]      dealt;
  logic [3:0]      card;
  logic [TO_W-1:0] watchdog;
  logic [3:0]      rank;
  logic            accept;
  logic            timeout_hit;
  logic            draw_ok;

  assign lfsr_next   = {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
  assign rank        = lfsr[3:0];
  assign accept      = (rank <= 4'd12) && (counts[rank] < 3'd4);
  assign timeout_hit = (watchdog == TO_W'(TIMEOUT - 1));
  assign draw_ok     = i_DrawReq && !i_Shuffle && !o_DeckEmpty;

  assign o_Card      = card;
  assign o_Busy      = (state != S_IDLE);
  assign o_DeckEmpty = (dealt == 6'd52);

  always_ff @(posedge clk_50M) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    o_RstCounter = 1'b0;
    o_Active     = 1'b0;
    o_CardValid  = 1'b0;
    o_Error      = 1'b0;
    case (state)
      S_IDLE: if (draw_ok) state_next = S_CLR;
      S_CLR: begin
        o_RstCounter = 1'b1;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (i_TwoSec) begin
          state_next = S_DRAW;
        end else begin
          o_Active = 1'b1;
          if (timeout_hit) begin
            o_Error    = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_DRAW: if (accept) state_next = S_DONE;
      S_DONE: begin
        o_CardValid = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Reset silences the Counter handshake in the very cycle it is asserted.
    if (i_Reset) begin
      o_RstCounter = 1'b0;
      o_Active     = 1'b0;
      o_CardValid  = 1'b0;
      o_Error      = 1'b0;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      lfsr     <= 12'hACE;
      dealt    <= '0;
      card     <= '0;
      watchdog <= '0;
      for (int i = 0; i < 16; i++) counts[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Shuffle) begin
            dealt <= '0;
            for (int i = 0; i < 16; i++) counts[i] <= '0;
          end else if (i_SeedLoad) begin
            lfsr <= (i_Seed[11:0] == 12'd0) ? 12'hACE : i_Seed[11:0];
          end
        end
        S_CLR:  watchdog <= '0;
        S_WAIT: watchdog <= watchdog + 1'b1;
        // A rejected window still advances the LFSR so the next cycle tries a new rank.
        S_DRAW: begin
          lfsr <= lfsr_next;
          if (accept) begin
            card         <= rank + 4'd1;
            counts[rank] <= counts[rank] + 3'd1;
            dealt        <= dealt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a small LFSR/deck reference model predicts every dealt card,
// and the Counter handshake, watchdog, shuffle and reset behaviour are checked by hand-counted cycles.
module tb_card_dealer;

  logic        clk_50M = 1'b0;
  logic        i_Reset = 1'b1;
  logic [11:0] i_Seed = 12'h000;
  logic        i_SeedLoad = 1'b0;
  logic        i_Shuffle = 1'b0;
  logic        i_DrawReq = 1'b0;
  logic        i_TwoSec = 1'b0;
  logic        o_RstCounter;
  logic        o_Active;
  logic [3:0]  o_Card;
  logic        o_CardValid;
  logic        o_Busy;
  logic        o_DeckEmpty;
  logic        o_Error;

  int checkCount = 0;
  int passCount  = 0;

  logic [11:0] mLfsr;
  int          mCount [16];
  int          mDealt;
  int          obsCount [16];

  card_dealer #(.WIDTH(12), .TIMEOUT(20), .TO_W(28)) dut (
    .clk_50M     (clk_50M),
    .i_Reset     (i_Reset),
    .i_Seed      (i_Seed),
    .i_SeedLoad  (i_SeedLoad),
    .i_Shuffle   (i_Shuffle),
    .i_DrawReq   (i_DrawReq),
    .i_TwoSec    (i_TwoSec),
    .o_RstCounter(o_RstCounter),
    .o_Active    (o_Active),
    .o_Card      (o_Card),
    .o_CardValid (o_CardValid),
    .o_Busy      (o_Busy),
    .o_DeckEmpty (o_DeckEmpty),
    .o_Error     (o_Error)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [11:0] seed, input logic seedLoad, input logic shuffle,
                               input logic drawReq, input logic twoSec);
    i_Seed     = seed;
    i_SeedLoad = seedLoad;
    i_Shuffle  = shuffle;
    i_DrawReq  = drawReq;
    i_TwoSec   = twoSec;
  endtask

  task automatic modelReset();
    mLfsr  = 12'hACE;
    mDealt = 0;
    for (int i = 0; i < 16; i++) mCount[i] = 0;
  endtask

  task automatic modelShuffle();
    mDealt = 0;
    for (int i = 0; i < 16; i++) mCount[i] = 0;
  endtask

  // Reference dealer: take the low nibble, accept if it is a valid rank with cards left, always step.
  task automatic modelDraw(output logic [3:0] card);
    int r;
    logic found;
    card  = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      r = int'(mLfsr[3:0]);
      if (r <= 12 && mCount[r] < 4) begin
        mCount[r]++;
        mDealt++;
        card  = 4'(r + 1);
        found = 1'b1;
      end
      mLfsr = {mLfsr[10:0], mLfsr[11] ^ mLfsr[10] ^ mLfsr[9] ^ mLfsr[3]};
    end
  endtask

  // Issues one draw request from IDLE and follows it until the dealer is idle again.
  // k counts negedges after acceptance: k=0 is CLR, WAIT starts at k=1.
  task automatic runDraw(input int delay, input logic holdReq, output logic [3:0] card,
                         output int activeCnt, output int rstCnt, output int validCnt);
    logic finished;
    activeCnt = 0;
    rstCnt    = 0;
    validCnt  = 0;
    card      = 4'd0;
    finished  = 1'b0;
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_50M);
    for (int k = 0; k < 6000 && !finished; k++) begin
      applyStimulus(12'h000, 1'b0, 1'b0, holdReq, (k >= 1 + delay));
      #1;
      if (o_RstCounter) rstCnt++;
      if (o_Active) activeCnt++;
      if (o_CardValid) begin
        validCnt++;
        card = o_Card;
      end
      if (!o_Busy) finished = 1'b1;
      else @(negedge clk_50M);
    end
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!finished) checkOutput("draw_within_budget", 32'd0, 32'd1);
  endtask

  task automatic drawAndCheck(input string tag, input int delay);
    logic [3:0] got, exp;
    int a, r, v;
    runDraw(delay, 1'b0, got, a, r, v);
    modelDraw(exp);
    checkOutput({tag, "_card"}, 32'(got), 32'(exp));
    checkOutput({tag, "_valid"}, 32'(v), 32'd1);
    if (got >= 4'd1 && got <= 4'd13) obsCount[got]++;
  endtask

  task automatic doShuffle();
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    modelShuffle();
  endtask

  function automatic logic [9:0] allOutputs();
    return {o_RstCounter, o_Active, o_Card, o_CardValid, o_Busy, o_DeckEmpty, o_Error};
  endfunction

  initial begin
    logic [3:0] card, exp;
    int activeCnt, rstCnt, validCnt, errK, errCnt;
    logic finished;

    modelReset();
    for (int i = 0; i < 16; i++) obsCount[i] = 0;

    // T1: reset values and seed capture
    @(negedge clk_50M);
    @(negedge clk_50M);
    i_Reset = 1'b0;
    #1;
    checkOutput("reset_outputs", 32'(allOutputs()), 32'd0);
    checkOutput("reset_lfsr", 32'(dut.lfsr), 32'h0ACE);
    applyStimulus(12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50M);
    #1;
    checkOutput("seed_zero_lfsr", 32'(dut.lfsr), 32'h0ACE);
    applyStimulus(12'h123, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("seed_123_lfsr", 32'(dut.lfsr), 32'h0123);
    mLfsr = 12'h123;

    // T2: single draw, Counter released five WAIT cycles after CLR
    runDraw(5, 1'b0, card, activeCnt, rstCnt, validCnt);
    modelDraw(exp);
    checkOutput("t2_rst_pulse", 32'(rstCnt), 32'd1);
    checkOutput("t2_active_cycles", 32'(activeCnt), 32'd5);
    checkOutput("t2_valid_count", 32'(validCnt), 32'd1);
    checkOutput("t2_card", 32'(card), 32'(exp));
    checkOutput("t2_card_in_range", 32'(card >= 4'd1 && card <= 4'd13), 32'd1);

    // T3: deal the whole deck with the timer already elapsed
    doShuffle();
    #1;
    checkOutput("t3_shuffle_dealt", 32'(dut.dealt), 32'd0);
    for (int i = 0; i < 16; i++) obsCount[i] = 0;
    for (int n = 0; n < 52; n++) drawAndCheck("t3_draw", 0);
    for (int rk = 1; rk <= 13; rk++) checkOutput($sformatf("t3_rank%0d_count", rk), 32'(obsCount[rk]), 32'd4);
    #1;
    checkOutput("t3_deck_empty", 32'(o_DeckEmpty), 32'd1);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t3_draw53_busy", 32'(o_Busy), 32'd0);
    validCnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_50M);
      #1;
      if (o_CardValid || o_Busy) validCnt++;
    end
    checkOutput("t3_draw53_no_activity", 32'(validCnt), 32'd0);

    // T4: watchdog expiry with the timer never elapsing
    doShuffle();
    for (int n = 0; n < 3; n++) drawAndCheck("t4_pre", 0);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_50M);
    errK      = -1;
    errCnt    = 0;
    activeCnt = 0;
    finished  = 1'b0;
    for (int k = 0; k < 100 && !finished; k++) begin
      applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (o_Active) activeCnt++;
      if (o_Error) begin
        errCnt++;
        errK = k;
      end
      if (!o_Busy) finished = 1'b1;
      else @(negedge clk_50M);
    end
    checkOutput("t4_error_cycle", 32'(errK), 32'd20);
    checkOutput("t4_error_pulses", 32'(errCnt), 32'd1);
    checkOutput("t4_active_cycles", 32'(activeCnt), 32'd20);
    checkOutput("t4_idle_after", 32'(o_Busy), 32'd0);
    checkOutput("t4_active_low", 32'(o_Active), 32'd0);
    checkOutput("t4_dealt_unchanged", 32'(dut.dealt), 32'd3);
    drawAndCheck("t4_post", 0);

    // T5: shuffle wins over a same-cycle draw; requests while busy are dropped
    for (int n = 0; n < 6; n++) drawAndCheck("t5_pre", 0);
    #1;
    checkOutput("t5_dealt10", 32'(dut.dealt), 32'd10);
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    modelShuffle();
    #1;
    checkOutput("t5_shuffle_draw_busy", 32'(o_Busy), 32'd0);
    checkOutput("t5_shuffle_dealt", 32'(dut.dealt), 32'd0);
    runDraw(5, 1'b1, card, activeCnt, rstCnt, validCnt);
    modelDraw(exp);
    checkOutput("t5_held_req_valid", 32'(validCnt), 32'd1);
    checkOutput("t5_held_req_card", 32'(card), 32'(exp));
    @(negedge clk_50M);
    #1;
    checkOutput("t5_no_queued_draw", 32'(o_Busy), 32'd0);
    checkOutput("t5_dealt1", 32'(dut.dealt), 32'd1);

    // T6: reset during WAIT, then during DRAW
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50M);
    @(negedge clk_50M);
    #1;
    checkOutput("t6_wait_active", 32'(o_Active), 32'd1);
    i_Reset = 1'b1;
    #1;
    checkOutput("t6_wait_active_drop", 32'(o_Active), 32'd0);
    @(negedge clk_50M);
    #1;
    checkOutput("t6_wait_outputs", 32'(allOutputs()), 32'd0);
    checkOutput("t6_wait_lfsr", 32'(dut.lfsr), 32'h0ACE);
    checkOutput("t6_wait_dealt", 32'(dut.dealt), 32'd0);
    i_Reset = 1'b0;
    modelReset();
    drawAndCheck("t6_after_reset", 0);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_50M);
    @(negedge clk_50M);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_draw_busy", 32'(o_Busy), 32'd1);
    i_Reset = 1'b1;
    @(negedge clk_50M);
    #1;
    checkOutput("t6_draw_outputs", 32'(allOutputs()), 32'd0);
    checkOutput("t6_draw_lfsr", 32'(dut.lfsr), 32'h0ACE);
    checkOutput("t6_draw_dealt", 32'(dut.dealt), 32'd0);
    i_Reset = 1'b0;
    modelReset();
    drawAndCheck("t6_final", 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
